// File: rtl/ascon_pkg.sv
// Shared Ascon core definitions: state type, controller FSM encoding,
// round-count constants and the round-constant helper.
package ascon_pkg;

    typedef logic [319:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_t;

    localparam int ROUNDS_A = 12;
    localparam int ROUNDS_B = 6;
    localparam int ROUNDS_8 = 8;

    // Rounds per clock for the permutation datapath across the core.
    localparam int UROL_CFG = 1;

    // Round constant for absolute round index 0..11: high nibble counts down
    // from 0xf while the low nibble counts up.
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {4'hf - idx, idx};
    endfunction

endpackage

// File: rtl/asconp.sv
// Combinational Ascon-p round datapath: UROL rounds per pass, the first one
// at absolute index 12-round_cnt (round_cnt = rounds still to be done).
module asconp
    import ascon_pkg::*;
#(
    parameter int UROL = UROL_CFG
) (
    input  logic [319:0] state_in,
    input  logic [3:0]   round_cnt,
    output logic [319:0] state_out
);

    function automatic state_t round_fn(input state_t s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, round_const(idx)};
        // Bitsliced 5-bit S-box
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        // Linear diffusion: each lane XORed with two right-rotations of itself
        x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
        x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
        x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
        x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
        x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
        return {x0, x1, x2, x3, x4};
    endfunction

    state_t st;

    always_comb begin
        st = state_in;
        for (int r = 0; r < UROL; r++) begin
            st = round_fn(st, 4'd12 - round_cnt + 4'(r));
        end
        state_out = st;
    end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation controller: accepts a state and round count, iterates the
// asconp datapath UROL rounds per clock, then holds the result until consumed.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int UROL = UROL_CFG
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid_i,
    output logic         start_ready_o,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [319:0] state_o,
    input  logic         abort_i,
    output logic         busy_o,
    output logic         err_o
);

    fsm_t       fsm_q, fsm_d;
    state_t     st_reg, st_d;
    logic [3:0] rcnt, rcnt_d;
    logic       err_q, err_d;
    state_t     dp_out;

    // Legal counts are also multiples of UROL, so rcnt lands exactly on UROL
    // and the down-count never wraps.
    function automatic logic rounds_legal(input logic [3:0] r);
        logic known;
        known = (r == 4'(ROUNDS_A)) || (r == 4'(ROUNDS_B)) || (r == 4'(ROUNDS_8));
        return known && ((int'(r) % UROL) == 0);
    endfunction

    asconp #(
        .UROL(UROL)
    ) u_asconp (
        .state_in (st_reg),
        .round_cnt(rcnt),
        .state_out(dp_out)
    );

    always_comb begin
        fsm_d         = fsm_q;
        st_d          = st_reg;
        rcnt_d        = rcnt;
        err_d         = 1'b0;
        start_ready_o = 1'b0;
        out_valid_o   = 1'b0;
        busy_o        = 1'b1;
        case (fsm_q)
            ST_IDLE: begin
                start_ready_o = 1'b1;
                busy_o        = 1'b0;
                // Abort outranks a start request in IDLE: nothing is consumed.
                if (!abort_i && start_valid_i) begin
                    if (rounds_legal(rounds_i)) begin
                        st_d   = state_i;
                        rcnt_d = rounds_i;
                        fsm_d  = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    fsm_d = ST_IDLE;
                end else begin
                    st_d   = dp_out;
                    rcnt_d = rcnt - 4'(UROL);
                    if (rcnt == 4'(UROL)) begin
                        fsm_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // An aborted result is never offered to the consumer.
                out_valid_o = !abort_i;
                if (abort_i || out_ready_i) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= ST_IDLE;
            st_reg <= '0;
            rcnt   <= '0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_reg <= st_d;
            rcnt   <= rcnt_d;
            err_q  <= err_d;
        end
    end

    assign state_o = st_reg;
    assign err_o   = err_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: one instance with UROL=1 and one with UROL=2,
// checked against a column-wise S-box-table model of Ascon-p.
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid [2];
    logic         start_ready [2];
    logic [3:0]   rounds      [2];
    logic [319:0] state_in    [2];
    logic         out_valid   [2];
    logic         out_ready   [2];
    logic [319:0] state_out   [2];
    logic         abort       [2];
    logic         busy        [2];
    logic         err         [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ascon_perm_ctrl #(.UROL(1)) dut_u1 (
        .clk(clk), .rst_n(rst_n),
        .start_valid_i(start_valid[0]), .start_ready_o(start_ready[0]),
        .rounds_i(rounds[0]), .state_i(state_in[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .state_o(state_out[0]), .abort_i(abort[0]),
        .busy_o(busy[0]), .err_o(err[0])
    );

    ascon_perm_ctrl #(.UROL(2)) dut_u2 (
        .clk(clk), .rst_n(rst_n),
        .start_valid_i(start_valid[1]), .start_ready_o(start_ready[1]),
        .rounds_i(rounds[1]), .state_i(state_in[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .state_o(state_out[1]), .abort_i(abort[1]),
        .busy_o(busy[1]), .err_o(err[1])
    );

    // ---------------- reference model ----------------
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam logic [7:0] RC [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [4:0]  col, o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ {56'd0, RC[r]};
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[col];
                for (int i = 0; i < 5; i++) x[i][b] = o[4 - i];
            end
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- checkers ----------------
    task automatic chk_b(input string nm, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic chk_i(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic chk_s(input string nm, input logic [319:0] a, input logic [319:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns cycles counted from the accept cycle.
    task automatic wait_valid(input int k, output int lat);
        lat = 1;
        while (!out_valid[k] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept(input int k, input logic [3:0] r, input logic [319:0] s);
        start_valid[k] = 1'b1;
        rounds[k]      = r;
        state_in[k]    = s;
        tick();
        start_valid[k] = 1'b0;
    endtask

    // One full request from IDLE; DUT must be idle on entry and is idle on exit.
    task automatic do_req(input int k, input logic [3:0] r, input logic [319:0] s,
                          input logic exp_err, input int exp_lat);
        int lat;
        accept(k, r, s);
        chk_b("err_pulse", err[k], exp_err);
        if (exp_err) begin
            chk_b("reject_busy", busy[k], 1'b0);
            tick();
            chk_b("err_one_cycle", err[k], 1'b0);
        end else begin
            chk_b("busy_run", busy[k], 1'b1);
            wait_valid(k, lat);
            chk_i("latency", lat, exp_lat);
            chk_s("result", state_out[k], ref_perm(s, int'(r)));
            chk_b("no_ready_done", start_ready[k], 1'b0);
            out_ready[k] = 1'b1;
            tick();
            out_ready[k] = 1'b0;
            chk_b("idle_after_done", busy[k], 1'b0);
            chk_b("valid_dropped", out_valid[k], 1'b0);
        end
    endtask

    typedef struct {
        int           k;
        logic [3:0]   r;
        logic [319:0] s;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [319:0] s, cap;
        logic [3:0]   picks [10];
        int           lat, k, cyc, last, acc, done;
        logic         hs, lg;
        logic [319:0] q [$];

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_valid[i] = 1'b0; rounds[i] = '0; state_in[i] = '0;
            out_ready[i] = 1'b0;   abort[i] = 1'b0;
        end

        // reset state
        tick();
        tick();
        chk_b("rst_valid", out_valid[0], 1'b0);
        chk_b("rst_busy", busy[0], 1'b0);
        chk_b("rst_err", err[0], 1'b0);
        chk_s("rst_state", state_out[0], '0);
        chk_i("rst_rcnt", int'(dut_u1.rcnt), 0);
        rst_n = 1'b1;
        tick();
        chk_b("rst_ready_u1", start_ready[0], 1'b1);
        chk_b("rst_ready_u2", start_ready[1], 1'b1);

        // table-driven vectors
        vt[0]  = '{0, 4'd12, '0,           1'b0, 13};
        vt[1]  = '{1, 4'd6,  rand_state(), 1'b0, 4};
        vt[2]  = '{0, 4'd5,  rand_state(), 1'b1, 0};
        vt[3]  = '{0, 4'd8,  rand_state(), 1'b0, 9};
        vt[4]  = '{1, 4'd12, rand_state(), 1'b0, 7};
        vt[5]  = '{1, 4'd8,  rand_state(), 1'b0, 5};
        vt[6]  = '{0, 4'd6,  rand_state(), 1'b0, 7};
        vt[7]  = '{1, 4'd7,  rand_state(), 1'b1, 0};
        vt[8]  = '{0, 4'd0,  rand_state(), 1'b1, 0};
        vt[9]  = '{1, 4'd15, rand_state(), 1'b1, 0};
        vt[10] = '{1, 4'd5,  rand_state(), 1'b1, 0};
        for (int i = 0; i < 11; i++) begin
            do_req(vt[i].k, vt[i].r, vt[i].s, vt[i].exp_err, vt[i].exp_lat);
        end

        // UROL=2, six rounds: counter walks 6,4,2 then DONE
        s = rand_state();
        accept(1, 4'd6, s);
        chk_i("rcnt_seq0", int'(dut_u2.rcnt), 6);
        tick();
        chk_i("rcnt_seq1", int'(dut_u2.rcnt), 4);
        tick();
        chk_i("rcnt_seq2", int'(dut_u2.rcnt), 2);
        chk_b("run_not_valid", out_valid[1], 1'b0);
        tick();
        chk_b("p6_valid", out_valid[1], 1'b1);
        chk_s("p6_result", state_out[1], ref_perm(s, 6));
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;

        // consumer stalls 10 cycles in DONE
        s = rand_state();
        accept(0, 4'd6, s);
        wait_valid(0, lat);
        chk_i("stall_latency", lat, 7);
        cap = ref_perm(s, 6);
        for (int i = 0; i < 10; i++) begin
            chk_b("stall_valid", out_valid[0], 1'b1);
            chk_s("stall_state", state_out[0], cap);
            chk_b("stall_ready", start_ready[0], 1'b0);
            tick();
        end
        out_ready[0] = 1'b1;
        chk_b("no_bypass", start_ready[0], 1'b0);
        tick();
        out_ready[0] = 1'b0;
        chk_b("stall_idle", busy[0], 1'b0);
        chk_b("stall_ready_back", start_ready[0], 1'b1);

        // abort in the second RUN cycle
        accept(0, 4'd8, rand_state());
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk_b("abort_run_busy", busy[0], 1'b0);
        chk_b("abort_run_valid", out_valid[0], 1'b0);
        chk_b("abort_run_err", err[0], 1'b0);
        tick();
        chk_b("abort_run_valid2", out_valid[0], 1'b0);
        do_req(0, 4'd12, rand_state(), 1'b0, 13);

        // abort while a result waits in DONE
        accept(1, 4'd6, rand_state());
        wait_valid(1, lat);
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        chk_b("abort_done_busy", busy[1], 1'b0);
        chk_b("abort_done_valid", out_valid[1], 1'b0);

        // abort in IDLE outranks a start request
        abort[0] = 1'b1;
        accept(0, 4'd8, rand_state());
        abort[0] = 1'b0;
        chk_b("abort_idle_busy", busy[0], 1'b0);
        chk_b("abort_idle_err", err[0], 1'b0);

        // reset mid-RUN
        accept(0, 4'd12, rand_state());
        tick();
        rst_n = 1'b0;
        #1;
        chk_b("rst_run_busy", busy[0], 1'b0);
        chk_b("rst_run_valid", out_valid[0], 1'b0);
        chk_s("rst_run_state", state_out[0], '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_b("rst_run_ready", start_ready[0], 1'b1);
        do_req(0, 4'd8, rand_state(), 1'b0, 9);

        // back-to-back, start_valid held high, consumer always ready
        out_ready[1]   = 1'b1;
        rounds[1]      = 4'd8;
        state_in[1]    = rand_state();
        start_valid[1] = 1'b1;
        cyc = 0; last = -1; acc = 0; done = 0;
        while ((acc < 3 || done < 3) && cyc < 100) begin
            if (out_valid[1]) begin
                if (q.size() > 0) chk_s("b2b_result", state_out[1], q.pop_front());
                else chk_b("b2b_spurious_valid", 1'b1, 1'b0);
                done++;
            end
            hs = start_valid[1] && start_ready[1];
            if (hs) begin
                if (last >= 0) chk_i("b2b_spacing", cyc - last, 6);
                last = cyc;
                q.push_back(ref_perm(state_in[1], 8));
                acc++;
            end
            tick();
            cyc++;
            if (hs) begin
                state_in[1] = rand_state();
                if (acc == 3) start_valid[1] = 1'b0;
            end
        end
        chk_i("b2b_accepts", acc, 3);
        chk_i("b2b_results", done, 3);
        out_ready[1] = 1'b0;
        tick();

        // randomized requests checked against the model's legality rules
        picks = '{4'd6, 4'd8, 4'd12, 4'd5, 4'd7, 4'd0, 4'd4, 4'd10, 4'd15, 4'd2};
        for (int i = 0; i < 24; i++) begin
            logic [3:0] r;
            k  = int'($urandom_range(0, 1));
            r  = picks[$urandom_range(0, 9)];
            lg = (r == 4'd6 || r == 4'd8 || r == 4'd12) && ((int'(r) % (k + 1)) == 0);
            do_req(k, r, rand_state(), !lg, int'(r) / (k + 1) + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
